// File: rtl/boid_raster_scheduler.sv
// boid_raster_scheduler: snapshots CPU boid slots each frame and rasterizes square sprites into display RAM
module boid_raster_scheduler #(
    parameter  int MAX_BOIDS    = 32,
    parameter  int SPRITE_SIZE  = 2,
    parameter  int VIDEO_WIDTH  = 640,
    parameter  int VIDEO_HEIGHT = 480,
    parameter  int ADDR_WIDTH   = 19,
    localparam int IDX_W        = $clog2(MAX_BOIDS)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cpu_we,
    input  logic [IDX_W-1:0]      cpu_idx,
    input  logic [9:0]            cpu_x,
    input  logic [8:0]            cpu_y,
    input  logic                  cpu_valid,
    input  logic                  frame_end,
    output logic                  pix_we,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic                  pix_ready,
    output logic                  buf_sel,
    output logic                  clear_req,
    output logic                  busy,
    output logic [7:0]            overrun_cnt
);
    localparam int               S_W    = SPRITE_SIZE > 1 ? $clog2(SPRITE_SIZE) : 1;
    localparam logic [10:0]      W_LIM  = 11'(VIDEO_WIDTH);
    localparam logic [9:0]       H_LIM  = 10'(VIDEO_HEIGHT);
    localparam logic [S_W-1:0]   S_LAST = S_W'(SPRITE_SIZE - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(MAX_BOIDS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;
    state_t state, state_nx;

    logic             live_v [MAX_BOIDS];
    logic [9:0]       live_x [MAX_BOIDS];
    logic [8:0]       live_y [MAX_BOIDS];
    logic             sh_v   [MAX_BOIDS];
    logic [9:0]       sh_x   [MAX_BOIDS];
    logic [8:0]       sh_y   [MAX_BOIDS];
    logic [IDX_W-1:0] idx;
    logic [S_W-1:0]   dx, dy;
    logic [10:0]      px;
    logic [9:0]       py;
    logic             start, skip, clip, last_px, step;

    assign start = state == IDLE && frame_end;

    // Current sprite pixel: position, visibility, and whether the scan may advance this cycle
    always_comb begin
        px      = {1'b0, sh_x[idx]} + 11'(dx);
        py      = {1'b0, sh_y[idx]} + 10'(dy);
        skip    = !sh_v[idx] || {1'b0, sh_x[idx]} >= W_LIM || {1'b0, sh_y[idx]} >= H_LIM;
        clip    = px >= W_LIM || py >= H_LIM;
        last_px = skip || (dx == S_LAST && dy == S_LAST);
        step    = state == SCAN && (skip || clip || pix_ready);
    end

    // CPU-writable live bank, updated in every state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_BOIDS; i++) begin
                live_v[i] <= 1'b0;
                live_x[i] <= '0;
                live_y[i] <= '0;
            end
        end else if (cpu_we) begin
            live_v[cpu_idx] <= cpu_valid;
            live_x[cpu_idx] <= cpu_x;
            live_y[cpu_idx] <= cpu_y;
        end
    end

    // Shadow bank frozen at frame start; a same-cycle CPU write bypasses into the snapshot
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_BOIDS; i++) begin
                sh_v[i] <= 1'b0;
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < MAX_BOIDS; i++) begin
                sh_v[i] <= cpu_we && cpu_idx == IDX_W'(i) ? cpu_valid : live_v[i];
                sh_x[i] <= cpu_we && cpu_idx == IDX_W'(i) ? cpu_x : live_x[i];
                sh_y[i] <= cpu_we && cpu_idx == IDX_W'(i) ? cpu_y : live_y[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end

    // FSM next state: one CLEAR cycle, SCAN until the last boid retires, one DONE cycle
    always_comb begin
        state_nx = state;
        if (start) state_nx = CLEAR;
        else if (state == CLEAR) state_nx = SCAN;
        else if (step && last_px && idx == I_LAST) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end

    // FSM outputs; pixel channel is driven purely from held state so it stays stable under backpressure
    always_comb begin
        busy      = state != IDLE;
        clear_req = state == CLEAR;
        pix_we    = state == SCAN && !skip && !clip;
        pix_addr  = pix_we ? ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(px) : '0;
    end

    // Scan indices (dy outer, dx inner), bank toggle and saturating overrun counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx         <= '0;
            dx          <= '0;
            dy          <= '0;
            buf_sel     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (start) buf_sel <= ~buf_sel;
            if (frame_end && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            if (state == CLEAR) begin
                idx <= '0;
                dx  <= '0;
                dy  <= '0;
            end else if (step) begin
                dx  <= last_px || dx == S_LAST ? '0 : dx + 1'b1;
                dy  <= last_px ? '0 : dx == S_LAST ? dy + 1'b1 : dy;
                idx <= last_px ? idx + 1'b1 : idx;
            end
        end
    end
endmodule

// File: tb/tb_boid_raster_scheduler.sv
// tb_boid_raster_scheduler: directed checks of snapshot, raster order, clipping, backpressure, overrun and reset
module tb_boid_raster_scheduler;
    localparam int AW = 19;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_we = 1'b0;
    logic [1:0]    cpu_idx = '0;
    logic [9:0]    cpu_x = '0;
    logic [8:0]    cpu_y = '0;
    logic          cpu_valid = 1'b0;
    logic          frame_end = 1'b0;
    logic          pix_ready = 1'b1;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic          buf_sel;
    logic          clear_req;
    logic          busy;
    logic [7:0]    overrun_cnt;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] wq[$];

    boid_raster_scheduler #(
        .MAX_BOIDS(4), .SPRITE_SIZE(2), .VIDEO_WIDTH(640), .VIDEO_HEIGHT(480), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .resetn(resetn), .cpu_we(cpu_we), .cpu_idx(cpu_idx), .cpu_x(cpu_x),
        .cpu_y(cpu_y), .cpu_valid(cpu_valid), .frame_end(frame_end), .pix_we(pix_we),
        .pix_addr(pix_addr), .pix_ready(pix_ready), .buf_sel(buf_sel), .clear_req(clear_req),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clock = ~clock;

    // Log every completed pixel write
    always @(posedge clock) if (resetn && pix_we && pix_ready) wq.push_back(pix_addr);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input int i, input int x, input int y, input bit v);
        @(negedge clock);
        cpu_we = 1'b1; cpu_idx = 2'(i); cpu_x = 10'(x); cpu_y = 9'(y); cpu_valid = v;
        @(negedge clock);
        cpu_we = 1'b0;
    endtask

    task automatic run_frame(output int cyc);
        wq.delete();
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        tests++;
        if ({pix_we, clear_req, busy, buf_sel, overrun_cnt, pix_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b clr=%b busy=%b sel=%b ovr=%0d addr=%0d, want all 0",
                     pix_we, clear_req, busy, buf_sel, overrun_cnt, pix_addr);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || pix_we !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b we=%b, want 0 0", busy, pix_we);
        end
    endtask

    task automatic test_sequence;
        int ew[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        int ea[10] = '{0, 0, 3210, 3211, 3850, 3851, 0, 0, 0, 0};
        int eb[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int ec[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        cpu_write(1, 10, 5, 1'b1);
        @(negedge clock);
        frame_end = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            frame_end = 1'b0;
            tests++;
            if (pix_we !== 1'(ew[c]) || busy !== 1'(eb[c]) || clear_req !== 1'(ec[c]) ||
                (ew[c] == 1 && pix_addr !== AW'(ea[c]))) begin
                fails++;
                $display("FAIL seq_cycle_T+%0d: got we=%b addr=%0d busy=%b clr=%b, want we=%0d addr=%0d busy=%0d clr=%0d",
                         c + 1, pix_we, pix_addr, busy, clear_req, ew[c], ea[c], eb[c], ec[c]);
            end
            if (c == 0) begin
                tests++;
                if (buf_sel !== 1'b1) begin
                    fails++;
                    $display("FAIL seq_buf_sel: got %b want 1", buf_sel);
                end
            end
        end
    endtask

    task automatic test_clip;
        int cyc;
        cpu_write(0, 639, 479, 1'b1);
        cpu_write(1, 700, 10, 1'b1);
        run_frame(cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL clip_frame_len: got %0d busy cycles want 9", cyc);
        end
        tests++;
        if (wq.size() != 1 || wq[0] !== AW'(307199)) begin
            fails++;
            $display("FAIL clip_writes: got %p want single 307199", wq);
        end
    endtask

    task automatic test_backpressure;
        int e[4] = '{3210, 3211, 3850, 3851};
        int cyc;
        bit bad;
        cpu_write(0, 0, 0, 1'b0);
        cpu_write(1, 10, 5, 1'b1);
        wq.delete();
        pix_ready = 1'b0;
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests++;
            if (pix_we !== 1'b1 || pix_addr !== AW'(3210)) begin
                fails++;
                $display("FAIL bp_hold_%0d: got we=%b addr=%0d want we=1 addr=3210", k, pix_we, pix_addr);
            end
        end
        pix_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
        tests++;
        bad = wq.size() != 4;
        for (int i = 0; i < 4 && !bad; i++) bad = wq[i] !== AW'(e[i]);
        if (bad || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_writes: got %p busy=%b want '{3210,3211,3850,3851} busy=0", wq, busy);
        end
    endtask

    task automatic test_overrun;
        int e[4] = '{3210, 3211, 3850, 3851};
        int cyc;
        bit bad;
        wq.delete();
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        @(negedge clock);
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        tests++;
        if (overrun_cnt !== 8'd1) begin
            fails++;
            $display("FAIL overrun_one: got %0d want 1", overrun_cnt);
        end
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
        tests++;
        bad = wq.size() != 4;
        for (int i = 0; i < 4 && !bad; i++) bad = wq[i] !== AW'(e[i]);
        if (bad || busy !== 1'b0) begin
            fails++;
            $display("FAIL overrun_scan_intact: got %p busy=%b want '{3210,3211,3850,3851} busy=0", wq, busy);
        end
        pix_ready = 1'b0;
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        for (int k = 0; k < 20 && !pix_we; k++) @(negedge clock);
        for (int k = 0; k < 300; k++) begin
            frame_end = 1'b1;
            @(negedge clock);
            frame_end = 1'b0;
            @(negedge clock);
        end
        tests++;
        if (overrun_cnt !== 8'd255) begin
            fails++;
            $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt);
        end
        tests++;
        if (pix_we !== 1'b1 || pix_addr !== AW'(3210)) begin
            fails++;
            $display("FAIL overrun_stall_hold: got we=%b addr=%0d want we=1 addr=3210", pix_we, pix_addr);
        end
        pix_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
        tests++;
        if (busy !== 1'b0 || overrun_cnt !== 8'd255) begin
            fails++;
            $display("FAIL overrun_after: got busy=%b ovr=%0d want 0 255", busy, overrun_cnt);
        end
    endtask

    task automatic test_snapshot;
        int e1[4] = '{12820, 12821, 13460, 13461};
        int e2[4] = '{30, 31, 670, 671};
        int cyc;
        bit bad;
        wq.delete();
        @(negedge clock);
        frame_end = 1'b1;
        cpu_we = 1'b1; cpu_idx = 2'd1; cpu_x = 10'd20; cpu_y = 9'd20; cpu_valid = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        cpu_we = 1'b0;
        @(negedge clock);
        @(negedge clock);
        cpu_we = 1'b1; cpu_idx = 2'd1; cpu_x = 10'd30; cpu_y = 9'd0; cpu_valid = 1'b1;
        @(negedge clock);
        cpu_we = 1'b0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
        tests++;
        bad = wq.size() != 4;
        for (int i = 0; i < 4 && !bad; i++) bad = wq[i] !== AW'(e1[i]);
        if (bad) begin
            fails++;
            $display("FAIL snap_same_cycle: got %p want '{12820,12821,13460,13461}", wq);
        end
        run_frame(cyc);
        tests++;
        bad = wq.size() != 4 || cyc != 9;
        for (int i = 0; i < 4 && !bad; i++) bad = wq[i] !== AW'(e2[i]);
        if (bad) begin
            fails++;
            $display("FAIL snap_next_frame: got %p len=%0d want '{30,31,670,671} len=9", wq, cyc);
        end
    endtask

    task automatic test_reset_midscan;
        int cyc;
        pix_ready = 1'b0;
        @(negedge clock);
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
        for (int k = 0; k < 20 && !pix_we; k++) @(negedge clock);
        tests++;
        if (pix_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_stall: got we=%b want 1", pix_we);
        end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({pix_we, clear_req, busy, buf_sel, overrun_cnt, pix_addr} !== '0) begin
            fails++;
            $display("FAIL rst_async: got we=%b clr=%b busy=%b sel=%b ovr=%0d addr=%0d, want all 0",
                     pix_we, clear_req, busy, buf_sel, overrun_cnt, pix_addr);
        end
        @(negedge clock);
        resetn = 1'b1;
        pix_ready = 1'b1;
        run_frame(cyc);
        tests++;
        if (wq.size() != 0 || cyc != 6 || buf_sel !== 1'b1) begin
            fails++;
            $display("FAIL rst_empty_frame: got writes=%0d len=%0d sel=%b want 0 6 1", wq.size(), cyc, buf_sel);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_clip();
        test_backpressure();
        test_overrun();
        test_snapshot();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
